usart_rx: RTL and testbench
===========================

// Module: usart_rx
// PURPOSE
//  Receive end of the Sigma Delta DAQ USART link; counterpart of the CRC8/parity USART transmitter.
//  Deserialises frames from the serial line and recomputes CRC8 over the payload.
//  Checks parity, CRC and stop bit; presents the payload on a valid/ready handshake with error flags.
//  Frame on sig_i: start(0), DATA LSB-first, CRC LSB-first, parity, stop(1); one bit = OVERSAMPLE clk.
// PARAMETERS
//  OVERSAMPLE     1                                  clk cycles per bit; 1 matches current TX (1 bit/clk)
//  CRC_LENGTH     8                                  CRC field width in bits
//  FRAME_BITS     USART_DATA_LENGTH+CRC_LENGTH       shifted payload+CRC bits
//  LB_FRAME       $clog2(FRAME_BITS)                 bit-counter width
// PORTS
//  clk            in   1                    system clock
//  rsnt           in   1                    reset, asynchronous, active-low
//  sig_i          in   1                    serial line, idle high
//  data_o         out  USART_DATA_LENGTH    received payload, stable while valid_o=1
//  valid_o        out  1                    payload available
//  ready_i        in   1                    consumer accepts when valid_o & ready_i
//  crc_err_o      out  1                    qualified by valid_o: CRC mismatch
//  parity_err_o   out  1                    qualified by valid_o: parity mismatch
//  frame_err_o    out  1                    1-cycle pulse: stop bit sampled 0, frame discarded
//  overrun_o      out  1                    1-cycle pulse: frame completed while valid_o=1, new frame dropped
// BEHAVIOUR
//  - One clock (clk). Reset asynchronous, active-low (rsnt): always_ff @(posedge clk or negedge rsnt).
//  - Reset values: data_o=0, valid_o=0, all error outputs 0, state=IDLE, counters 0.
//  - Sample timing: start detected on sig_i=0 in IDLE.
//    Start is re-checked after OVERSAMPLE/2 cycles (0 when OVERSAMPLE=1); if high, return to IDLE (glitch).
//    Subsequent bits are sampled every OVERSAMPLE cycles.
//  - FSM: IDLE -> START -> SHIFT -> PARITY -> STOP -> CHECK -> (IDLE | RESYNC).
//    SHIFT: shift_r[bit_cnt] <= sample; par_r ^= sample; leave after bit_cnt==FRAME_BITS-1.
//    par_r is loaded with USART_PARITY_MODE at START.
//    PARITY: parity_err = sample != par_r.
//    STOP: sample 0 -> frame_err_o pulse, discard frame, go to RESYNC.
//    RESYNC waits for sig_i=1, then goes to IDLE.
//  - CRC: existing CRC8 #(.DATA_LENGTH(USART_DATA_LENGTH)) is instanced on the payload bits.
//    crc_valid is pulsed 1 cycle after the last payload bit shifts in; CRC8 runs during CRC/parity/stop.
//    CHECK holds until crc_ready; crc_err = CRC8 result != received CRC.
//    crc_clear is pulsed 1 cycle on leaving CHECK.
//  - Output: on CHECK exit, if valid_o=0, load data_o and error flags, set valid_o=1.
//    If valid_o=1, drop the frame and pulse overrun_o.
//    valid_o clears the cycle after valid_o & ready_i; data_o is held until then.
//  - Latency (OVERSAMPLE=1, CRC8 ready within frame): valid_o rises 1 cycle after the stop-bit sample.
//  - Back-to-back: IDLE is re-entered the cycle after CHECK exit; a start bit sampled that cycle is accepted.
//    Start bits arriving during CHECK are lost. TX inter-frame gap is >=3 cycles, so this never triggers with our TX.
//  - Reset mid-frame: all state cleared immediately; partial frame lost, no flags raised.
//  - Simultaneous accept (ready_i) and frame completion in the same cycle: new frame loads, no overrun.
// CONFIGURATION
//  USART_RX_SYNC_EN defined: sig_i passes through a 2-flop synchronizer (reset value 1) before the FSM.
//    All latencies grow by 2 cycles.
//  Undefined: sig_i is used directly (same-clock TX loopback only).
// STRUCTURE
//  Shared package usart_pkg:
//    - rx state enum (IDLE, START, SHIFT, PARITY, STOP, CHECK, RESYNC)
//    - CRC_LENGTH constant
//    - rx_status_t struct {crc_err, parity_err}
//  USART_DATA_LENGTH and USART_PARITY_MODE stay in UsartParam.svh.
//  Sub-modules: CRC8 reused unchanged; bit sampling stays inline, no new sub-module.
// TESTING (USART_DATA_LENGTH=8, OVERSAMPLE=1, loopback from the USART transmitter)
//  - TX 0xA5, ready_i=1 -> one valid_o with data_o=0xA5, crc_err_o=0, parity_err_o=0.
//  - Back-to-back TX 0x00, 0xFF, 0x3C -> three valid_o beats in order, no overrun_o, no errors.
//  - Flip CRC bit 0 of a 0x5A frame on the line -> data_o=0x5A, crc_err_o=1, parity_err_o=1.
//  - Flip only the parity bit -> parity_err_o=1, crc_err_o=0.
//  - Force stop bit to 0 -> frame_err_o 1-cycle pulse, no valid_o, next frame 0x11 received clean.
//  - Hold ready_i=0 over 2 frames -> first frame held stable, overrun_o pulse on second.
//    Deassert rsnt mid-SHIFT -> outputs reset immediately, next frame received correctly.

Source files
------------

// File: rtl/usart_pkg.sv
// usart_pkg: shared types and constants for the DAQ USART link.
// Holds the link-wide payload width, parity mode, CRC width and RX FSM types.
package usart_pkg;

    localparam int USART_DATA_LENGTH = 8;
    // 0 = even parity, 1 = odd parity (seed of the running parity)
    localparam logic USART_PARITY_MODE = 1'b0;
    localparam int CRC_LENGTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        PARITY,
        STOP,
        CHECK,
        RESYNC
    } rx_state_t;

    typedef struct packed {
        logic crc_err;
        logic parity_err;
    } rx_status_t;

endpackage

// File: rtl/crc8.sv
// crc8: serial CRC-8 (poly x^8+x^2+x+1, init 0x00, MSB-first) over a parallel word.
// crc_valid_i loads the word; one bit is folded in per clock; crc_ready_o rises
// when all DATA_LENGTH bits are done and stays high until crc_clear_i or a new load.
module crc8 #(
    parameter int DATA_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rsnt,
    input  logic [DATA_LENGTH-1:0] data_i,
    input  logic                   crc_valid_i,
    input  logic                   crc_clear_i,
    output logic [7:0]             crc_o,
    output logic                   crc_ready_o
);

    localparam logic [7:0] POLY = 8'h07;
    localparam int CW = $clog2(DATA_LENGTH + 1);

    logic [DATA_LENGTH-1:0] data_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q;
    logic                   fb;

    assign fb = crc_o[7] ^ data_q[DATA_LENGTH-1];

    // Load on valid, then fold one data bit per cycle until the counter empties.
    always_ff @(posedge clk or negedge rsnt) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rsnt) begin
            data_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            crc_o       <= '0;
            crc_ready_o <= 1'b0;
        end else if (crc_valid_i) begin
            data_q      <= data_i;
            cnt_q       <= CW'(DATA_LENGTH);
            busy_q      <= 1'b1;
            crc_o       <= '0;
            crc_ready_o <= 1'b0;
        end else if (crc_clear_i) begin
            busy_q      <= 1'b0;
            crc_ready_o <= 1'b0;
        end else if (busy_q) begin
            crc_o  <= {crc_o[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
            data_q <= data_q << 1;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_q      <= 1'b0;
                crc_ready_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/usart_rx.sv
// usart_rx: receive end of the DAQ USART link.
// Frame on sig_i: start(0), data LSB-first, CRC8 LSB-first, parity, stop(1);
// one bit lasts OVERSAMPLE clocks. Payload leaves on a valid/ready handshake
// with CRC and parity flags; frame errors and overruns are 1-cycle pulses.
// Build option: define USART_RX_SYNC_EN to add a 2-flop synchronizer on sig_i
// (all latencies grow by 2 cycles); otherwise sig_i is used directly.
module usart_rx
    import usart_pkg::*;
#(
    parameter int OVERSAMPLE = 1
) (
    input  logic                         clk,
    input  logic                         rsnt,
    input  logic                         sig_i,
    output logic [USART_DATA_LENGTH-1:0] data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         crc_err_o,
    output logic                         parity_err_o,
    output logic                         frame_err_o,
    output logic                         overrun_o
);

    localparam int FRAME_BITS = USART_DATA_LENGTH + CRC_LENGTH;
    localparam int LB_FRAME   = $clog2(FRAME_BITS);
    localparam int HALF       = OVERSAMPLE / 2;
    // With HALF==0 the detection sample is the re-check, so START waits a full bit.
    localparam int START_WAIT = (HALF == 0) ? OVERSAMPLE - 1 : HALF - 1;
    localparam int OS_W       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [LB_FRAME-1:0] LAST_BIT   = LB_FRAME'(FRAME_BITS - 1);
    localparam logic [LB_FRAME-1:0] LAST_DATA  = LB_FRAME'(USART_DATA_LENGTH - 1);
    localparam logic [OS_W-1:0]     OS_RELOAD  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]     START_LOAD = OS_W'(START_WAIT);

    rx_state_t             state_q, state_d;
    logic                  line;
    logic [OS_W-1:0]       os_cnt_q;
    logic                  chk_pend_q;
    logic [LB_FRAME-1:0]   bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  par_q;
    logic                  par_err_q;
    logic                  crc_valid_q;
    logic                  crc_clear;
    logic                  crc_ready;
    logic [7:0]            crc_calc;
    logic                  tick;
    logic                  check_done;
    rx_status_t            status_q;

`ifdef USART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rsnt) begin
        if (!rsnt) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], sig_i};
    end

    assign line = sync_q[1];
`else
    assign line = sig_i;
`endif

    assign tick       = (os_cnt_q == '0);
    assign check_done = (state_q == CHECK) && crc_ready;

    // State register.
    always_ff @(posedge clk or negedge rsnt) begin
        if (!rsnt) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and CRC clear strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        crc_clear = 1'b0;
        case (state_q)
            IDLE:   if (!line) state_d = START;
            START:  if (tick) begin
                        if (chk_pend_q) begin
                            if (line) state_d = IDLE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
            SHIFT:  if (tick && bit_cnt_q == LAST_BIT) state_d = PARITY;
            PARITY: if (tick) state_d = STOP;
            STOP:   if (tick) state_d = line ? CHECK : RESYNC;
            CHECK:  if (crc_ready) begin
                        crc_clear = 1'b1;
                        state_d   = IDLE;
                    end
            RESYNC: if (line) begin
                        crc_clear = 1'b1;
                        state_d   = IDLE;
                    end
            default: state_d = IDLE;
        endcase
    end

    // Bit sampling: timing counter, shift register, running parity and CRC launch.
    always_ff @(posedge clk or negedge rsnt) begin
        if (!rsnt) begin
            os_cnt_q    <= '0;
            chk_pend_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            par_err_q   <= 1'b0;
            crc_valid_q <= 1'b0;
        end else begin
            crc_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    os_cnt_q   <= START_LOAD;
                    chk_pend_q <= (HALF != 0);
                    bit_cnt_q  <= '0;
                end
                START: begin
                    if (!tick) begin
                        os_cnt_q <= os_cnt_q - 1'b1;
                    end else begin
                        os_cnt_q <= OS_RELOAD;
                        if (chk_pend_q) begin
                            chk_pend_q <= 1'b0;
                        end else begin
                            shift_q[0]  <= line;
                            par_q       <= USART_PARITY_MODE ^ line;
                            bit_cnt_q   <= LB_FRAME'(1);
                            crc_valid_q <= (USART_DATA_LENGTH == 1);
                        end
                    end
                end
                SHIFT: begin
                    if (!tick) begin
                        os_cnt_q <= os_cnt_q - 1'b1;
                    end else begin
                        os_cnt_q           <= OS_RELOAD;
                        shift_q[bit_cnt_q] <= line;
                        par_q              <= par_q ^ line;
                        bit_cnt_q          <= bit_cnt_q + 1'b1;
                        crc_valid_q        <= (bit_cnt_q == LAST_DATA);
                    end
                end
                PARITY: begin
                    if (!tick) begin
                        os_cnt_q <= os_cnt_q - 1'b1;
                    end else begin
                        os_cnt_q  <= OS_RELOAD;
                        par_err_q <= (line != par_q);
                    end
                end
                STOP: begin
                    if (!tick) os_cnt_q <= os_cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output handshake: load a checked frame, hold until accepted, flag overruns.
    always_ff @(posedge clk or negedge rsnt) begin
        if (!rsnt) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            status_q    <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= (state_q == STOP) && tick && !line;
            overrun_o   <= 1'b0;
            if (check_done) begin
                if (!valid_o || ready_i) begin
                    valid_o             <= 1'b1;
                    data_o              <= shift_q[USART_DATA_LENGTH-1:0];
                    status_q.crc_err    <= (crc_calc != shift_q[FRAME_BITS-1 -: CRC_LENGTH]);
                    status_q.parity_err <= par_err_q;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign crc_err_o    = status_q.crc_err;
    assign parity_err_o = status_q.parity_err;

    crc8 #(
        .DATA_LENGTH(USART_DATA_LENGTH)
    ) u_crc8 (
        .clk        (clk),
        .rsnt       (rsnt),
        .data_i     (shift_q[USART_DATA_LENGTH-1:0]),
        .crc_valid_i(crc_valid_q),
        .crc_clear_i(crc_clear),
        .crc_o      (crc_calc),
        .crc_ready_o(crc_ready)
    );

endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx: directed bench for usart_rx (8-bit payload, OVERSAMPLE=1).
// A behavioural transmitter builds frames with a reference CRC-8 and parity;
// a negedge monitor records accepted beats and error pulses.
module tb_usart_rx;
    import usart_pkg::*;

    logic       clk;
    logic       rsnt;
    logic       sig_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       crc_err_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       crc_err;
        logic       par_err;
    } beat_t;

    beat_t beats[$];
    int    fe_cnt = 0;
    int    ov_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       flip_crc0;
        logic       flip_par;
        logic       bad_stop;
        int         exp_beats;
        logic       exp_crc_err;
        logic       exp_par_err;
        int         exp_fe;
    } vec_t;

    vec_t vecs[7];

    usart_rx #(.OVERSAMPLE(1)) dut (
        .clk         (clk),
        .rsnt        (rsnt),
        .sig_i       (sig_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .crc_err_o   (crc_err_o),
        .parity_err_o(parity_err_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after posedge, so the negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (valid_o && ready_i) beats.push_back('{data_o, crc_err_o, parity_err_o});
        if (frame_err_o) fe_cnt++;
        if (overrun_o)   ov_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] crc8_ref(input logic [7:0] d);
        logic [7:0] c;
        c = d;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #2;
        sig_i = b;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_crc0,
                              input logic flip_par, input logic bad_stop);
        logic [7:0] c;
        logic       p;
        c = crc8_ref(d);
        p = USART_PARITY_MODE ^ (^d) ^ (^c);
        if (flip_crc0) c[0] = ~c[0];
        if (flip_par)  p = ~p;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        for (int i = 0; i < 8; i++) drive_bit(c[i]);
        drive_bit(p);
        drive_bit(~bad_stop);
        if (bad_stop) drive_bit(1'b1);
    endtask

    task automatic clear_log();
        beats.delete();
        fe_cnt = 0;
        ov_cnt = 0;
    endtask

    initial begin
        //           data   fcrc  fpar  bstop beats crc   par   fe
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0};
        vecs[1] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 0};
        vecs[2] = '{8'h33, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h77, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1};
        vecs[4] = '{8'h11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0};
        vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 0};

        rsnt    = 1'b0;
        sig_i   = 1'b1;
        ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset valid_o", valid_o, 0);
        check("reset data_o", data_o, 0);
        check("reset crc_err_o", crc_err_o, 0);
        check("reset parity_err_o", parity_err_o, 0);
        check("reset frame_err_o", frame_err_o, 0);
        check("reset overrun_o", overrun_o, 0);
        rsnt = 1'b1;
        wait_cycles(3);

        // Single frames through the table, consumer always ready.
        ready_i = 1'b1;
        for (int v = 0; v < 7; v++) begin
            clear_log();
            send_frame(vecs[v].data, vecs[v].flip_crc0, vecs[v].flip_par, vecs[v].bad_stop);
            wait_cycles(4);
            check($sformatf("vec%0d beats", v), beats.size(), vecs[v].exp_beats);
            if (beats.size() > 0) begin
                check($sformatf("vec%0d data", v), beats[0].data, vecs[v].data);
                check($sformatf("vec%0d crc_err", v), beats[0].crc_err, vecs[v].exp_crc_err);
                check($sformatf("vec%0d parity_err", v), beats[0].par_err, vecs[v].exp_par_err);
            end
            check($sformatf("vec%0d frame_err pulses", v), fe_cnt, vecs[v].exp_fe);
            check($sformatf("vec%0d overrun pulses", v), ov_cnt, 0);
        end

        // Back-to-back with a single idle cycle: start lands the cycle IDLE is re-entered.
        clear_log();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        wait_cycles(1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        wait_cycles(1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_cycles(4);
        check("b2b beats", beats.size(), 3);
        if (beats.size() == 3) begin
            check("b2b data0", beats[0].data, 8'h00);
            check("b2b data1", beats[1].data, 8'hFF);
            check("b2b data2", beats[2].data, 8'h3C);
            check("b2b errs", {beats[0].crc_err, beats[0].par_err, beats[1].crc_err,
                               beats[1].par_err, beats[2].crc_err, beats[2].par_err}, 0);
        end
        check("b2b overrun", ov_cnt, 0);

        // Consumer stalled: latency of valid_o, hold of data_o, overrun on the second frame.
        ready_i = 1'b0;
        clear_log();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("latency valid low at stop sample", valid_o, 0);
        @(negedge clk);
        check("latency valid high one cycle later", valid_o, 1);
        check("latency data", data_o, 8'hC3);
        wait_cycles(2);
        send_frame(8'h96, 1'b0, 1'b0, 1'b0);
        wait_cycles(4);
        check("stall overrun pulses", ov_cnt, 1);
        check("stall valid held", valid_o, 1);
        check("stall data held", data_o, 8'hC3);

        // Accept and frame completion in the same cycle: new frame loads, no overrun.
        send_frame(8'h69, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        ready_i = 1'b1;
        @(posedge clk);
        #2;
        ready_i = 1'b0;
        wait_cycles(2);
        check("simul overrun pulses", ov_cnt, 1);
        check("simul valid", valid_o, 1);
        check("simul data", data_o, 8'h69);
        ready_i = 1'b1;
        wait_cycles(3);
        check("simul beats", beats.size(), 2);
        if (beats.size() == 2) begin
            check("simul beat0", beats[0].data, 8'hC3);
            check("simul beat1", beats[1].data, 8'h69);
        end

        // Reset in the middle of SHIFT while a frame is held on the output.
        ready_i = 1'b0;
        clear_log();
        send_frame(8'h2D, 1'b0, 1'b0, 1'b0);
        wait_cycles(3);
        check("pre-reset valid", valid_o, 1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(posedge clk);
        #2;
        rsnt  = 1'b0;
        sig_i = 1'b1;
        #1;
        check("mid reset valid_o", valid_o, 0);
        check("mid reset data_o", data_o, 0);
        check("mid reset flags", {crc_err_o, parity_err_o, frame_err_o, overrun_o}, 0);
        wait_cycles(2);
        rsnt    = 1'b1;
        ready_i = 1'b1;
        wait_cycles(2);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        wait_cycles(4);
        check("post reset beats", beats.size(), 1);
        if (beats.size() == 1) begin
            check("post reset data", beats[0].data, 8'h11);
            check("post reset errs", {beats[0].crc_err, beats[0].par_err}, 0);
        end
        check("post reset frame_err", fe_cnt, 0);
        check("post reset overrun", ov_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
